// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_BITS data LSB-first, optional
// parity, 1 or 2 stop bits. Advances only on baud_clk strobes.
// Ports:
//   clk, rst_n  - system clock, async active-low reset
//   baud_clk    - one-clk strobe per bit period
//   i_data      - word to send, captured on accept (i_valid && o_ready)
//   i_valid     - upstream has data
//   o_ready     - one-deep holding register is empty
//   o_tx        - registered serial line, idle high
//   o_busy      - registered, high while a frame is on the line
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   hold_q;
  logic                   hold_full_q, hold_full_d;
  logic [2:0]             idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   load;
  logic                   accept;

  assign accept  = i_valid && !hold_full_q;
  assign o_ready = !hold_full_q;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    load    = 1'b0;
    if (baud_clk) begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) load = 1'b1;
        end
        START: begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
        DATA: begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? PAR : STOP;
            stop_d  = 1'b0;
          end
        end
        PAR: begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
        STOP: begin
          if (stop_q == LAST_STOP) begin
            if (hold_full_q) load = 1'b1;
            else state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Load from IDLE or straight out of the last stop bit (gapless).
    if (load) begin
      state_d = START;
      shreg_d = hold_q;
      idx_d   = 3'd0;
      stop_d  = 1'b0;
      par_d   = (PARITY == 1) ? ~(^hold_q) : ^hold_q;
    end
  end

  // Line value is computed from the next state so o_tx can be a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PAR:     tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Accept is only possible when empty, load only when full; accept
  // wins so a same-edge pair would leave the new word pending.
  assign hold_full_d = accept | (hold_full_q & ~load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= 3'd0;
      stop_q      <= 1'b0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      if (accept) hold_q <= i_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: 8N1, 8E1 and 8O2 instances
// share clock, reset and an 8-clk baud strobe.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            baud = 1'b0;
  logic [2:0]      valid = '0;
  logic [2:0][7:0] din = '0;
  logic [2:0]      ready;
  logic [2:0]      tx;
  logic [2:0]      busy;
  int              checks = 0;
  int              errors = 0;

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud), .i_data(din[0]),
    .i_valid(valid[0]), .o_ready(ready[0]), .o_tx(tx[0]),
    .o_busy(busy[0])
  );

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud), .i_data(din[1]),
    .i_valid(valid[1]), .o_ready(ready[1]), .o_tx(tx[1]),
    .o_busy(busy[1])
  );

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud), .i_data(din[2]),
    .i_valid(valid[2]), .o_ready(ready[2]), .o_tx(tx[2]),
    .o_busy(busy[2])
  );

  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      repeat (7) @(negedge clk);
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge after the next strobe edge; flags any
  // change of tx[k] on the non-strobe edges in between.
  task automatic wait_strobe(input int k, output logic changed);
    logic t0;
    logic hit;
    int   n;
    t0      = tx[k];
    hit     = 1'b0;
    n       = 0;
    changed = 1'b0;
    while (!hit && n < 64) begin
      @(posedge clk);
      hit = baud;
      @(negedge clk);
      if (!hit && tx[k] !== t0) changed = 1'b1;
      n++;
    end
    chk("strobe_seen", 32'(hit), 1);
  endtask

  task automatic check_seq(input int k, input string s, input string tag);
    logic ch;
    logic e;
    for (int i = 0; i < s.len(); i++) begin
      e = (s.getc(i) == 8'h31);
      chk($sformatf("%s_bit%0d", tag, i), 32'(tx[k]), 32'(e));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy[k]), 1);
      wait_strobe(k, ch);
      chk($sformatf("%s_hold%0d", tag, i), 32'(ch), 0);
    end
    chk({tag, "_end_tx"}, 32'(tx[k]), 1);
    chk({tag, "_end_busy"}, 32'(busy[k]), 0);
  endtask

  task automatic push(input int k, input logic [7:0] b, output int n);
    valid[k] = 1'b1;
    din[k]   = b;
    n        = 0;
    while (!ready[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(ready[k]), 1);
    @(posedge clk);
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  initial begin
    logic ch;
    int   n;
    int   n2;
    int   bad_tx;
    int   bad_rdy;
    int   bad_busy;

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'h7);
    chk("rst_ready", 32'(ready), 32'h7);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    bad_tx = 0; bad_rdy = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 3'b111) bad_tx++;
      if (ready !== 3'b111) bad_rdy++;
      if (busy !== 3'b000) bad_busy++;
    end
    chk("idle_tx", 32'(bad_tx), 0);
    chk("idle_ready", 32'(bad_rdy), 0);
    chk("idle_busy", 32'(bad_busy), 0);

    // 8N1 0xA5
    wait_strobe(0, ch);
    push(0, 8'hA5, n);
    chk("a5_ready_low", 32'(ready[0]), 0);
    chk("a5_pre_busy", 32'(busy[0]), 0);
    chk("a5_pre_tx", 32'(tx[0]), 1);
    wait_strobe(0, ch);
    check_seq(0, "0101001011", "n1_a5");

    // Three words with valid held: gapless, third back-pressured
    push(0, 8'h55, n);
    wait_strobe(0, ch);
    fork
      check_seq(0, {"0101010101", "0111100001", "0000011111"}, "b2b");
      begin
        push(0, 8'h0F, n2);
        push(0, 8'hF0, n2);
        chk("b2b_stall_cycles", 32'(n2), 79);
      end
    join

    // 8E1 and 8O2 parity / stop bits
    push(1, 8'hA5, n);
    wait_strobe(1, ch);
    check_seq(1, "01010010101", "e1_a5");
    push(1, 8'h01, n);
    wait_strobe(1, ch);
    check_seq(1, "01000000011", "e1_01");

    push(2, 8'hA5, n);
    wait_strobe(2, ch);
    fork
      check_seq(2, {"010100101111", "010000000011"}, "o2");
      push(2, 8'h01, n2);
    join

    // Reset during data bit 3 of 0x3C with another word pending
    push(0, 8'h3C, n);
    wait_strobe(0, ch);
    push(0, 8'h00, n);
    repeat (4) wait_strobe(0, ch);
    chk("rst_mid_bit3", 32'(tx[0]), 1);
    chk("rst_mid_busy_pre", 32'(busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx[0]), 1);
    chk("rst_mid_busy", 32'(busy[0]), 0);
    chk("rst_mid_ready", 32'(ready[0]), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) bad_tx++;
      if (busy[0] !== 1'b0) bad_busy++;
    end
    chk("post_rst_tx", 32'(bad_tx), 0);
    chk("post_rst_busy", 32'(bad_busy), 0);
    wait_strobe(0, ch);
    push(0, 8'h81, n);
    wait_strobe(0, ch);
    check_seq(0, "0100000011", "n1_81");

    // Accept on the same edge as a strobe while idle
    repeat (7) @(negedge clk);
    valid[0] = 1'b1;
    din[0]   = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    chk("coin_ready", 32'(ready[0]), 0);
    chk("coin_tx", 32'(tx[0]), 1);
    chk("coin_busy", 32'(busy[0]), 0);
    wait_strobe(0, ch);
    chk("coin_idle_hold", 32'(ch), 0);
    check_seq(0, "0110000111", "coin");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
